// File: rtl/filter_sample_sequencer_if.sv
// Handshake bundle between the sample sequencer and the filter bank.
// filt_ready pulses for one cycle once filt_switch and filt_sample are settled. The first
// filt_done in the wait window returns filt_audio. filt_done outside that window is ignored.
interface filter_sample_sequencer_if;
  logic [1:0] filt_switch;
  logic       filt_ready;
  logic [7:0] filt_sample;
  logic       filt_done;
  logic [7:0] filt_audio;

  modport master (output filt_switch, filt_ready, filt_sample,
                  input  filt_done, filt_audio);
  modport slave  (input  filt_switch, filt_ready, filt_sample,
                  output filt_done, filt_audio);
endinterface

// File: rtl/filter_sample_sequencer.sv
// Paces ADC samples into the filter bank, captures results for the DAC stage, mutes after a
// filter change and flags missing results (timeout) and samples lost while busy (overrun).
module filter_sample_sequencer #(
  parameter int SAMPLE_DIV     = 2272,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MUTE_SAMPLES   = 31
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [1:0]                       sw_req,
  input  logic                             adc_valid,
  input  logic [7:0]                       adc_sample,
  filter_sample_sequencer_if.master        bank,
  output logic [7:0]                       pcm_out,
  output logic                             pcm_valid,
  output logic                             busy,
  output logic                             timeout_err,
  output logic                             overrun_err,
  output logic [1:0]                       state_dbg
);

  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int MUTE_W = (MUTE_SAMPLES > 0) ? $clog2(MUTE_SAMPLES + 1) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [MUTE_W-1:0] MUTE_INIT = MUTE_W'(MUTE_SAMPLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [1:0]        sw_meta, sw_sync;
  logic [7:0]        adc_hold;
  logic [DIV_W-1:0]  div_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [MUTE_W-1:0] mute_cnt;
  logic              tick;
  logic              latch_sample;
  logic              take_done;
  logic              take_timeout;

  assign tick      = (div_cnt == DIV_LAST);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Done is checked before the timeout so a result on the last allowed cycle is still taken.
  always_comb begin
    next_state   = state;
    latch_sample = 1'b0;
    take_done    = 1'b0;
    take_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick) begin
          latch_sample = 1'b1;
          next_state   = ST_ARM;
        end
      end
      ST_ARM: next_state = ST_WAIT;
      ST_WAIT: begin
        if (bank.filt_done) begin
          take_done  = 1'b1;
          next_state = ST_IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          take_timeout = 1'b1;
          next_state   = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_meta          <= '0;
      sw_sync          <= '0;
      adc_hold         <= '0;
      div_cnt          <= '0;
      wait_cnt         <= '0;
      mute_cnt         <= '0;
      bank.filt_switch <= '0;
      bank.filt_ready  <= 1'b0;
      bank.filt_sample <= '0;
      pcm_out          <= '0;
      pcm_valid        <= 1'b0;
      timeout_err      <= 1'b0;
      overrun_err      <= 1'b0;
    end else begin
      sw_meta <= sw_req;
      sw_sync <= sw_meta;
      if (adc_valid) adc_hold <= adc_sample;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;

      // Registered from ARM so the switch has been stable for a full cycle at the strobe.
      bank.filt_ready <= (state == ST_ARM);
      pcm_valid       <= take_done | take_timeout;

      if (tick && (state != ST_IDLE)) overrun_err <= 1'b1;

      if (latch_sample) begin
        bank.filt_sample <= adc_hold;
        bank.filt_switch <= sw_sync;
        if (sw_sync != bank.filt_switch) mute_cnt <= MUTE_INIT;
      end

      if (state == ST_ARM)       wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;

      if (take_done) begin
        pcm_out <= (mute_cnt != '0) ? 8'h00 : bank.filt_audio;
        if (mute_cnt != '0) mute_cnt <= mute_cnt - 1'b1;
      end

      if (take_timeout) begin
        pcm_out     <= 8'h00;
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_filter_sample_sequencer.sv
// Directed-plus-random bench for filter_sample_sequencer with a transaction-level model of
// pacing, muting and error flags; a second, faster-ticking instance exercises overrun.
module tb_filter_sample_sequencer;

  localparam int DIV  = 100;
  localparam int TMO  = 64;
  localparam int MUTE = 4;
  localparam int DIV2 = 50;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rst2  = 1'b1;
  logic [1:0] sw_req  = 2'b00;
  logic [1:0] sw_req2 = 2'b00;
  logic       adc_valid  = 1'b0;
  logic [7:0] adc_sample = 8'h00;

  logic [7:0] pcm_out, pcm_out2;
  logic       pcm_valid, pcm_valid2;
  logic       busy, busy2;
  logic       timeout_err, timeout_err2;
  logic       overrun_err, overrun_err2;
  logic [1:0] state_dbg, state_dbg2;

  filter_sample_sequencer_if bank ();
  filter_sample_sequencer_if bank2 ();

  filter_sample_sequencer #(.SAMPLE_DIV(DIV), .TIMEOUT_CYCLES(TMO), .MUTE_SAMPLES(MUTE)) dut (
    .clock(clock), .reset(reset), .sw_req(sw_req), .adc_valid(adc_valid),
    .adc_sample(adc_sample), .bank(bank), .pcm_out(pcm_out), .pcm_valid(pcm_valid),
    .busy(busy), .timeout_err(timeout_err), .overrun_err(overrun_err), .state_dbg(state_dbg)
  );

  filter_sample_sequencer #(.SAMPLE_DIV(DIV2), .TIMEOUT_CYCLES(TMO), .MUTE_SAMPLES(MUTE)) dut2 (
    .clock(clock), .reset(rst2), .sw_req(sw_req2), .adc_valid(adc_valid),
    .adc_sample(adc_sample), .bank(bank2), .pcm_out(pcm_out2), .pcm_valid(pcm_valid2),
    .busy(busy2), .timeout_err(timeout_err2), .overrun_err(overrun_err2), .state_dbg(state_dbg2)
  );

  // Clock / reset support
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state and reference model
  int         n_cmp = 0;
  int         n_bad = 0;
  int         last_ready = 0;
  logic [1:0] m_sw   = 2'b00;
  int         m_mute = 0;
  logic [7:0] m_adc  = 8'h00;
  logic [7:0] m_pcm  = 8'h00;
  logic       m_tmo  = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sw = 2'b00; m_mute = 0; m_adc = 8'h00; m_pcm = 8'h00; m_tmo = 1'b0;
  endtask

  // One sample: wait for the strobe, answer after 'delay' cycles (negative = never), reload ADC.
  task automatic run_sample(input string tag, input int exp_at, input int delay,
                            input logic [7:0] audio, input logic [1:0] sw_mid,
                            input logic [7:0] next_adc);
    logic [1:0] pre;
    int         k;
    pre = bank.filt_switch;
    for (k = 0; k < 250; k++) begin
      @(negedge clock);
      if (bank.filt_ready === 1'b1) break;
      pre = bank.filt_switch;
    end
    chk($sformatf("%s.ready_cycle", tag), cyc, exp_at);
    last_ready = cyc;
    if (sw_req != m_sw) m_mute = MUTE;
    m_sw = sw_req;
    chk($sformatf("%s.switch_before_ready", tag), pre, m_sw);
    chk($sformatf("%s.filt_sample", tag), bank.filt_sample, m_adc);
    chk($sformatf("%s.busy_high", tag), busy, 1'b1);
    sw_req = sw_mid;
    if (delay >= 0) begin
      repeat (delay) @(negedge clock);
      bank.filt_done  = 1'b1;
      bank.filt_audio = audio;
      @(negedge clock);
      bank.filt_done  = 1'b0;
      bank.filt_audio = ~audio;
      exp_q.push_back((m_mute > 0) ? 8'h00 : audio);
      if (m_mute > 0) m_mute--;
      chk($sformatf("%s.switch_held", tag), bank.filt_switch, m_sw);
      chk($sformatf("%s.pcm_valid", tag), pcm_valid, 1'b1);
    end else begin
      for (k = 1; k <= TMO + 8; k++) begin
        @(negedge clock);
        if (pcm_valid === 1'b1) break;
      end
      exp_q.push_back(8'h00);
      m_tmo = 1'b1;
      chk($sformatf("%s.timeout_latency", tag), k, TMO);
    end
    m_pcm = exp_q.pop_front();
    chk($sformatf("%s.pcm_out", tag), pcm_out, m_pcm);
    chk($sformatf("%s.timeout_err", tag), timeout_err, m_tmo);
    chk($sformatf("%s.overrun_err", tag), overrun_err, 1'b0);
    chk($sformatf("%s.busy_low", tag), busy, 1'b0);
    @(negedge clock);
    chk($sformatf("%s.pcm_valid_strobe", tag), pcm_valid, 1'b0);
    chk($sformatf("%s.pcm_out_held", tag), pcm_out, m_pcm);
    adc_sample = next_adc;
    adc_valid  = 1'b1;
    @(negedge clock);
    adc_valid  = 1'b0;
    adc_sample = 8'($urandom);
    m_adc      = next_adc;
  endtask

  initial begin
    int         rel, k, r2;
    logic [7:0] a2, a3, v2;

    bank.filt_done = 1'b0;  bank.filt_audio = 8'h00;
    bank2.filt_done = 1'b0; bank2.filt_audio = 8'h00;
    adc_sample = 8'h25;
    adc_valid  = 1'b1;
    repeat (3) @(negedge clock);

    // Reset state
    chk("rst.pcm_out", pcm_out, 8'h00);
    chk("rst.pcm_valid", pcm_valid, 1'b0);
    chk("rst.filt_ready", bank.filt_ready, 1'b0);
    chk("rst.filt_switch", bank.filt_switch, 2'b00);
    chk("rst.filt_sample", bank.filt_sample, 8'h00);
    chk("rst.busy", busy, 1'b0);
    chk("rst.timeout_err", timeout_err, 1'b0);
    chk("rst.overrun_err", overrun_err, 1'b0);
    chk("rst.overrun_err2", overrun_err2, 1'b0);

    reset = 1'b0;
    rel   = cyc;
    model_reset();
    m_adc = 8'h25;

    // Fixed pattern: 8'h25 in, 8'h12 back after 33 cycles, one strobe per 100 cycles
    run_sample("basic0", rel + DIV + 1, 33, 8'h12, 2'b00, 8'h25);
    run_sample("basic1", last_ready + DIV, 33, 8'h12, 2'b00, 8'h25);
    run_sample("basic2", last_ready + DIV, 33, 8'h12, 2'b00, 8'($urandom));

    // Done while idle is ignored
    bank.filt_done  = 1'b1;
    bank.filt_audio = 8'($urandom_range(1, 255));
    @(negedge clock);
    bank.filt_done  = 1'b0;
    chk("idle_done.pcm_valid", pcm_valid, 1'b0);
    chk("idle_done.pcm_out", pcm_out, m_pcm);

    for (int i = 0; i < 4; i++)
      run_sample($sformatf("rand%0d", i), last_ready + DIV, $urandom_range(0, TMO - 2),
                 8'($urandom_range(1, 255)), 2'b00, 8'($urandom));

    // Done on the last allowed wait cycle beats the timeout
    run_sample("done_at_limit", last_ready + DIV, TMO - 1, 8'($urandom_range(1, 255)),
               2'b00, 8'($urandom));

    // Switch moved mid-sample, then four muted completions with a timeout in between
    run_sample("sw_change", last_ready + DIV, 20, 8'($urandom_range(1, 255)), 2'b10, 8'($urandom));
    run_sample("mute1", last_ready + DIV, $urandom_range(0, 50), 8'($urandom_range(1, 255)), 2'b10, 8'($urandom));
    run_sample("mute2", last_ready + DIV, $urandom_range(0, 50), 8'($urandom_range(1, 255)), 2'b10, 8'($urandom));
    run_sample("timeout", last_ready + DIV, -1, 8'h00, 2'b10, 8'($urandom));
    run_sample("mute3", last_ready + DIV, $urandom_range(0, 50), 8'($urandom_range(1, 255)), 2'b10, 8'($urandom));
    run_sample("mute4", last_ready + DIV, $urandom_range(0, 50), 8'($urandom_range(1, 255)), 2'b10, 8'($urandom));
    run_sample("unmuted", last_ready + DIV, $urandom_range(0, 50), 8'($urandom_range(1, 255)), 2'b10, 8'($urandom));

    // Asynchronous reset on the strobe cycle
    for (k = 0; k < 250; k++) begin
      @(negedge clock);
      if (bank.filt_ready === 1'b1) break;
    end
    chk("rst_wait.ready_seen", cyc, last_ready + DIV);
    reset = 1'b1;
    #1;
    chk("rst_wait.filt_ready", bank.filt_ready, 1'b0);
    chk("rst_wait.busy", busy, 1'b0);
    chk("rst_wait.pcm_out", pcm_out, 8'h00);
    chk("rst_wait.timeout_err", timeout_err, 1'b0);
    chk("rst_wait.filt_switch", bank.filt_switch, 2'b00);
    chk("rst_wait.filt_sample", bank.filt_sample, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    rel   = cyc;
    model_reset();
    run_sample("after_rst", rel + DIV + 1, 10, 8'($urandom_range(1, 255)), 2'b10, 8'($urandom));

    // Overrun on the faster instance: result stretched onto the next tick
    v2 = 8'($urandom_range(1, 255));
    a2 = 8'($urandom_range(1, 255));
    a3 = 8'($urandom_range(1, 255));
    rst2       = 1'b0;
    rel        = cyc;
    adc_sample = v2;
    adc_valid  = 1'b1;
    for (k = 0; k < 150; k++) begin
      @(negedge clock);
      adc_valid = 1'b0;
      if (bank2.filt_ready === 1'b1) break;
    end
    chk("ovr.first_ready", cyc, rel + DIV2 + 1);
    r2 = cyc;
    chk("ovr.filt_sample", bank2.filt_sample, v2);
    repeat (DIV2 - 2) @(negedge clock);
    bank2.filt_done  = 1'b1;
    bank2.filt_audio = a2;
    @(negedge clock);
    bank2.filt_done  = 1'b0;
    chk("ovr.pcm_valid", pcm_valid2, 1'b1);
    chk("ovr.pcm_out", pcm_out2, a2);
    chk("ovr.overrun_err", overrun_err2, 1'b1);
    chk("ovr.timeout_err", timeout_err2, 1'b0);
    for (k = 0; k < 150; k++) begin
      @(negedge clock);
      if (bank2.filt_ready === 1'b1) break;
    end
    chk("ovr.resume_ready", cyc, r2 + 2 * DIV2);
    bank2.filt_done  = 1'b1;
    bank2.filt_audio = a3;
    @(negedge clock);
    bank2.filt_done  = 1'b0;
    chk("ovr.resume_pcm_valid", pcm_valid2, 1'b1);
    chk("ovr.resume_pcm_out", pcm_out2, a3);
    chk("ovr.sticky", overrun_err2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
